// File: rtl/calc_pkg.sv
// Shared constants for the sequential calculator: opcodes, widths and FSM encoding.
package calc_pkg;

    localparam int OPW  = 8;
    localparam int RESW = 16;
    localparam int CNTW = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } calc_state_e;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative datapath: shift-add multiply or restoring divide, one step per clock.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int ITER = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            is_div_i,
    input  logic [OPW-1:0]  a_i,
    input  logic [OPW-1:0]  b_i,
    output logic            done_o,
    output logic [RESW-1:0] result_o
);

    logic            busy_q, busy_d;
    logic            is_div_q, is_div_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [RESW-1:0] acc_q, acc_d;
    logic [RESW-1:0] mcand_q, mcand_d;
    logic [OPW-1:0]  b_q, b_d;
    logic [OPW:0]    shifted;
    logic [OPW-1:0]  rem_sub;

    always_comb begin
        busy_d   = busy_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        b_d      = b_q;
        done_o   = 1'b0;
        // For DIV acc holds {remainder, dividend/quotient}; bits shift left through it.
        shifted  = {acc_q[15:8], acc_q[7]};
        rem_sub  = shifted[7:0] - b_q;
        if (start_i) begin
            busy_d   = 1'b1;
            is_div_d = is_div_i;
            cnt_d    = '0;
            b_d      = b_i;
            mcand_d  = {8'b0, a_i};
            acc_d    = is_div_i ? {8'b0, a_i} : '0;
        end else if (busy_q) begin
            if (is_div_q) begin
                if (shifted >= {1'b0, b_q})
                    acc_d = {rem_sub, acc_q[6:0], 1'b1};
                else
                    acc_d = {shifted[7:0], acc_q[6:0], 1'b0};
            end else begin
                if (b_q[0])
                    acc_d = acc_q + mcand_q;
                mcand_d = mcand_q << 1;
                b_d     = b_q >> 1;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNTW'(ITER - 1)) begin
                busy_d = 1'b0;
                done_o = 1'b1;
            end
        end
    end

    // The final step's value is offered combinationally so the caller can register it on the same edge.
    assign result_o = acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            b_q      <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            b_q      <= b_d;
        end
    end

endmodule

// File: rtl/seq_calculator.sv
// Sequential calculator: single-cycle ADD/SUB, iterative MUL/DIV, one request in flight.
module seq_calculator
    import calc_pkg::*;
#(
    parameter int ITER = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  A,
    input  logic [OPW-1:0]  B,
    input  logic [1:0]      opcode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RESW-1:0] result,
    output logic            error_flag,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready; the
    // sender holds data stable while valid is high and ready is low.
    calc_state_e     state_q, state_d;
    logic [RESW-1:0] result_q, result_d;
    logic            error_q, error_d;
    logic            iter_start;
    logic            iter_done;
    logic [RESW-1:0] iter_result;
    logic [OPW:0]    sum9;

    assign sum9 = {1'b0, A} + {1'b0, B};

    calc_iter_unit #(.ITER(ITER)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start_i  (iter_start),
        .is_div_i (opcode == OP_DIV),
        .a_i      (A),
        .b_i      (B),
        .done_o   (iter_done),
        .result_o (iter_result)
    );

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        error_d    = error_q;
        iter_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    error_d = 1'b0;
                    state_d = DONE;
                    case (opcode)
                        OP_ADD: result_d = {7'b0, sum9};
                        OP_SUB: result_d = {8'b0, A} - {8'b0, B};
                        default: begin
                            if (opcode == OP_DIV && B == '0) begin
                                result_d = '0;
                                error_d  = 1'b1;
                            end else begin
                                iter_start = 1'b1;
                                state_d    = BUSY;
                            end
                        end
                    endcase
                end
            end
            BUSY: begin
                if (iter_done) begin
                    result_d = iter_result;
                    error_d  = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign result     = result_q;
    assign error_flag = error_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed-vector bench for seq_calculator: results, error flag, latency, stall and reset abort.
module tb_seq_calculator;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [1:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        error_flag;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    seq_calculator #(.ITER(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .error_flag (error_flag),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one request, check latency/result/error, optionally stall the response, then hand it off.
    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [15:0] exp_res, input logic exp_err, input int exp_lat, input int stall);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready before"}, {15'b0, in_ready}, 16'h0001);
        A = a; B = b; opcode = op; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 8'($urandom_range(0, 255));
        B = 8'($urandom_range(0, 255));
        opcode = 2'($urandom_range(0, 3));
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 16'(lat), 16'(exp_lat));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " error"}, {15'b0, error_flag}, {15'b0, exp_err});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " stall result"}, result, exp_res);
            chk({tag, " stall valid/ready"}, {14'b0, out_valid, in_ready}, 16'h0002);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " after hs valid/ready"}, {14'b0, out_valid, in_ready}, 16'h0001);
        chk({tag, " after hs result held"}, result, exp_res);
    endtask

    initial begin
        int seen_valid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 8'h00; B = 8'h00; opcode = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {13'b0, in_ready, out_valid, error_flag}, 16'h0004);
        chk("reset result", result, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        run("add 10+5",    8'd10,  8'd5,   2'b00, 16'h000F, 1'b0, 1, 0);
        run("add 255+255", 8'd255, 8'd255, 2'b00, 16'h01FE, 1'b0, 1, 0);
        run("sub 5-10",    8'd5,   8'd10,  2'b01, 16'hFFFB, 1'b0, 1, 0);
        run("sub 10-5",    8'd10,  8'd5,   2'b01, 16'h0005, 1'b0, 1, 0);
        run("mul 4*3",     8'd4,   8'd3,   2'b10, 16'h000C, 1'b0, 9, 0);
        run("mul 255*255", 8'd255, 8'd255, 2'b10, 16'hFE01, 1'b0, 9, 0);
        run("div 8/2",     8'd8,   8'd2,   2'b11, 16'h0004, 1'b0, 9, 0);
        run("div 17/5",    8'd17,  8'd5,   2'b11, 16'h0203, 1'b0, 9, 0);
        run("div 200/7",   8'd200, 8'd7,   2'b11, 16'h041C, 1'b0, 9, 0);
        run("div 8/0",     8'd8,   8'd0,   2'b11, 16'h0000, 1'b1, 1, 0);
        run("mul stall",   8'd13,  8'd11,  2'b10, 16'h008F, 1'b0, 9, 5);
        run("add stall",   8'd1,   8'd2,   2'b00, 16'h0003, 1'b0, 1, 5);

        // Reset in the middle of a MUL must drop the request entirely.
        @(negedge clk);
        A = 8'd9; B = 8'd9; opcode = 2'b10; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort outputs", {13'b0, in_ready, out_valid, error_flag}, 16'h0004);
        chk("abort result", result, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        out_ready = 1'b0;
        chk("abort no response", 16'(seen_valid), 16'h0000);
        run("add after abort", 8'd100, 8'd27, 2'b00, 16'h007F, 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
